divider_pipelined_param: RTL
============================

Name: divider_pipelined_param

Overview:
Parametrised, fully pipelined integer divider for the multicycle/pipelined datapath. It produces both quotient and remainder, with signed or unsigned mode chosen per request, and RISC-V M-extension results for the corner cases. It accepts one operation per cycle and carries a valid bit and a global stall through every stage. It is the drop-in divide unit that the execute stage instantiates for DIV/DIVU/REM/REMU.

Parameters:
WIDTH, 32, operand/result width in bits; must be ≥4 and even.
ITERS_PER_STAGE, 4, restoring-division iterations per pipeline stage; must divide WIDTH evenly.
(derived) STAGES = WIDTH/ITERS_PER_STAGE, which is both the pipeline depth and the latency in cycles.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous, active-high reset.
i_valid  in  1  request present this cycle.
i_signed  in  1  1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU).
i_dividend  in  WIDTH  dividend.
i_divisor  in  WIDTH  divisor.
i_stall  in  1  1 = freeze every pipeline register.
o_valid  out  1  result on o_quotient/o_remainder is valid.
o_quotient  out  WIDTH  quotient.
o_remainder  out  WIDTH  remainder.
o_busy  out  1  OR of the valid bits of all stages.

Behaviour:
- Reset: synchronous. On the edge where rst=1, all stage valid bits, data registers and special-case flags clear to 0. After reset o_valid=0, o_quotient=0, o_remainder=0, o_busy=0. A reset in mid-operation discards all in-flight requests; no result ever emerges for them.
- Acceptance: a request is accepted on a rising edge where i_valid=1, i_stall=0 and rst=0. There is no ready signal; the upstream stage must not present new work while it holds i_stall.
- Latency: a request accepted at edge n drives o_valid=1 during the cycle after edge n+STAGES−1. That is STAGES cycles after acceptance, or 8 cycles for the defaults. Throughput is 1 result per cycle with no bubbles.
- Stall: while i_stall=1, every valid bit, data register and output holds its value, and the inputs are ignored. A stall on the same edge as rst=1 loses to reset.
- Stage 0 (combinational, before the first register):
  - In signed mode, take the absolute value of each operand. |−2^(WIDTH−1)| is represented as unsigned 2^(WIDTH−1).
  - Record neg_q = sign(dividend) XOR sign(divisor), and neg_r = sign(dividend).
  - Record div0 = (divisor==0) and ovf = signed & dividend==−2^(WIDTH−1) & divisor==−1.
  - Carry the original dividend alongside for the div0 case.
- Each stage: perform ITERS_PER_STAGE iterations of shift-subtract restoring division, MSB-first.
  - Per iteration: rem = {rem[WIDTH−2:0], dvd_msb}; if rem ≥ dvs then rem −= dvs and q bit = 1, else q bit = 0.
  - Remainder arithmetic uses WIDTH+1 bits internally so that no compare overflows.
  - Stage state (dividend shift register, partial remainder, partial quotient, divisor, flags, valid) registers at the end of the stage.
- Output fix-up (combinational from the last register). Precedence is div0 > ovf > normal.
  - div0: quotient = all ones, remainder = original dividend. This holds in both modes.
  - ovf: quotient = −2^(WIDTH−1), remainder = 0.
  - normal signed: quotient negated if neg_q; remainder negated if neg_r. Division truncates toward zero.
  - normal unsigned: raw quotient and remainder.
- When o_valid=0, the outputs show the last-stage register contents. These are don't-care, except after reset, when they are 0.
- o_busy is combinational from the stage valid bits. The o_valid term is included.

Optional Feature:
Macro DIVIDER_FLUSH_EN.
- Defined: adds input port i_flush (1 bit). On an edge where i_flush=1 and rst=0, every stage valid bit clears; data registers are unchanged. i_flush overrides i_stall. A request presented on the same edge as i_flush is dropped.
- Undefined: the port does not exist, and in-flight work can only be discarded by rst.

Test Plan:
1. Unsigned basic, defaults: rst for 2 cycles, then i_valid=1, i_signed=0, 100/7 for one cycle → o_valid=1 exactly 8 cycles later, quotient=14, remainder=2; o_valid=0 on every other cycle.
2. Signed sign rules: back-to-back requests −7/2, 7/−2, −7/−2 on consecutive cycles → three consecutive o_valid cycles with (q,r) = (−3,−1), (−3,1), (3,−1).
3. Corner cases: 0x1234/0 unsigned → q=0xFFFFFFFF, r=0x1234. −5/0 signed → q=−1, r=−5. 0x80000000/−1 signed → q=0x80000000, r=0.
4. Stall: issue 0xFFFFFFFF/0x10 unsigned, assert i_stall for 3 cycles at cycle 4 → result (q=0x0FFFFFFF, r=0xF) appears at cycle 11, with outputs frozen during the stall.
5. Reset mid-flight: issue 4 requests, assert rst at cycle 3 → o_valid stays 0 for the following 10 cycles and o_busy=0 immediately after the reset edge.
6. Parameter sweep: WIDTH=16, ITERS_PER_STAGE=1 and 16, with 1000 random signed/unsigned operands compared against a reference model → latency of 16 and 1 cycles respectively, all results match.

Source files
------------

// File: rtl/divider_pipelined_param.sv
// -----------------------------------------------------------------------------
// divider_pipelined_param
//
// Purpose:
//   Fully pipelined restoring integer divider that produces quotient and
//   remainder. Signed or unsigned mode is chosen per request. The corner cases
//   return RISC-V M-extension results (divide-by-zero, signed overflow).
//   The unit accepts one request per cycle. Latency is STAGES =
//   WIDTH/ITERS_PER_STAGE cycles. A global stall freezes every pipeline
//   register.
//
// Parameters:
//   WIDTH            operand/result width (>= 4, even)
//   ITERS_PER_STAGE  shift-subtract iterations per stage (must divide WIDTH)
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   i_valid      request present this cycle
//   i_signed     1 = signed (DIV/REM), 0 = unsigned (DIVU/REMU)
//   i_dividend   dividend
//   i_divisor    divisor
//   i_stall      1 = hold every pipeline register, inputs ignored
//   i_flush      (only with DIVIDER_FLUSH_EN) clear every stage valid bit
//   o_valid      result on o_quotient/o_remainder is valid
//   o_quotient   quotient
//   o_remainder  remainder
//   o_busy       OR of all stage valid bits
//
// Optional feature macro: DIVIDER_FLUSH_EN
//   When this macro is defined, the module gets the i_flush input.
// -----------------------------------------------------------------------------
module divider_pipelined_param #(
    parameter int WIDTH           = 32,
    parameter int ITERS_PER_STAGE = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_valid,
    input  logic             i_signed,
    input  logic [WIDTH-1:0] i_dividend,
    input  logic [WIDTH-1:0] i_divisor,
    input  logic             i_stall,
`ifdef DIVIDER_FLUSH_EN
    input  logic             i_flush,
`endif
    output logic             o_valid,
    output logic [WIDTH-1:0] o_quotient,
    output logic [WIDTH-1:0] o_remainder,
    output logic             o_busy
);

    localparam int STAGES = WIDTH / ITERS_PER_STAGE;
    localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

    // Complete state of one in-flight request. The dividend shift register
    // (dvd) feeds its MSB into the partial remainder on each iteration.
    typedef struct packed {
        logic             valid;
        logic             neg_q;
        logic             neg_r;
        logic             div0;
        logic             ovf;
        logic [WIDTH-1:0] dvd;
        logic [WIDTH-1:0] rem;
        logic [WIDTH-1:0] quo;
        logic [WIDTH-1:0] dvs;
        logic [WIDTH-1:0] orig;
    } stage_t;

    stage_t prep_s;
    stage_t stage_in_s [STAGES];
    stage_t stage_d    [STAGES];
    stage_t stage_q    [STAGES];
    stage_t last_s;

    // Run ITERS_PER_STAGE restoring iterations, MSB first. The working
    // remainder is WIDTH+1 bits, so the compare with the divisor never
    // overflows.
    function automatic stage_t run_iters(input stage_t st);
        stage_t           r;
        logic [WIDTH:0]   rem_w;
        r = st;
        for (int i = 0; i < ITERS_PER_STAGE; i++) begin
            rem_w = {r.rem, r.dvd[WIDTH-1]};
            r.dvd = {r.dvd[WIDTH-2:0], 1'b0};
            if (rem_w >= {1'b0, r.dvs}) begin
                rem_w = rem_w - {1'b0, r.dvs};
                r.quo = {r.quo[WIDTH-2:0], 1'b1};
            end else begin
                r.quo = {r.quo[WIDTH-2:0], 1'b0};
            end
            r.rem = rem_w[WIDTH-1:0];
        end
        return r;
    endfunction

    // Operand preparation: magnitudes, sign flags and corner-case flags.
    // Negating the most negative value gives the unsigned 2^(WIDTH-1), which is
    // the magnitude we want.
    always_comb begin
        logic sgn_dvd;
        logic sgn_dvs;
        sgn_dvd      = i_signed & i_dividend[WIDTH-1];
        sgn_dvs      = i_signed & i_divisor[WIDTH-1];
        prep_s       = '0;
        prep_s.valid = i_valid;
        prep_s.neg_q = sgn_dvd ^ sgn_dvs;
        prep_s.neg_r = sgn_dvd;
        prep_s.div0  = (i_divisor == '0);
        prep_s.ovf   = i_signed & (i_dividend == MIN_VAL) & (i_divisor == '1);
        prep_s.dvd   = sgn_dvd ? (WIDTH'(0) - i_dividend) : i_dividend;
        prep_s.dvs   = sgn_dvs ? (WIDTH'(0) - i_divisor) : i_divisor;
        prep_s.rem   = '0;
        prep_s.quo   = '0;
        prep_s.orig  = i_dividend;
    end

    // Stage 0 takes the prepared operands. Every later stage takes the previous
    // stage register.
    for (genvar s = 0; s < STAGES; s++) begin : g_stage_in
        if (s == 0) begin : g_first
            assign stage_in_s[s] = prep_s;
        end else begin : g_rest
            assign stage_in_s[s] = stage_q[s-1];
        end
    end

    // Next state of each stage: its ITERS_PER_STAGE iterations.
    always_comb begin
        for (int s = 0; s < STAGES; s++) begin
            stage_d[s] = run_iters(stage_in_s[s]);
        end
    end

    // Pipeline registers. Priority is reset, then flush, then stall.
    // A flush clears only the valid bits.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= '0;
            end
`ifdef DIVIDER_FLUSH_EN
        end else if (i_flush) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s].valid <= 1'b0;
            end
`endif
        end else if (!i_stall) begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= stage_d[s];
            end
        end else begin
            for (int s = 0; s < STAGES; s++) begin
                stage_q[s] <= stage_q[s];
            end
        end
    end

    assign last_s = stage_q[STAGES-1];

    // Output fix-up from the last stage. Precedence is div0, then ovf,
    // then normal. Sign fix-up uses flags that are only set in signed mode.
    always_comb begin
        o_valid = last_s.valid;
        if (last_s.div0) begin
            o_quotient  = '1;
            o_remainder = last_s.orig;
        end else if (last_s.ovf) begin
            o_quotient  = MIN_VAL;
            o_remainder = '0;
        end else begin
            o_quotient  = last_s.neg_q ? (WIDTH'(0) - last_s.quo) : last_s.quo;
            o_remainder = last_s.neg_r ? (WIDTH'(0) - last_s.rem) : last_s.rem;
        end
    end

    // Busy whenever any stage holds a valid request, including the last one.
    always_comb begin
        o_busy = 1'b0;
        for (int s = 0; s < STAGES; s++) begin
            o_busy = o_busy | stage_q[s].valid;
        end
    end

endmodule
